// File: rtl/dot_result_collect_pkg.sv
// Shared widths, packet layout and FSM encoding for the dot-product result collector.
package dot_result_collect_pkg;

  localparam int FFLAGS_W  = 5;
  localparam int REG_IDX_W = 8;

  localparam int DEF_SHAPE_N = 4;
  localparam int DEF_ELEM_W  = 9;
  localparam int DEF_WARP_W  = 4;

  // Packet layout at the default configuration; the collector re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_SHAPE_N*DEF_ELEM_W-1:0] data;
    logic [FFLAGS_W-1:0]               fflags;
    logic [REG_IDX_W-1:0]              reg_idxw;
    logic [DEF_WARP_W-1:0]             warpid;
  } dot_pkt_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} fill_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dot_result_collect_sync_fifo.sv
// Single-clock packet FIFO; push on a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo
  import dot_result_collect_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dot_result_collect.sv
// Packs SHAPE_N reduction-tree results into one writeback packet, buffered in a small FIFO.
// Define DOT_RESULT_COLLECT_FFLAGS_EN to OR-accumulate exception flags per packet.
module dot_result_collect
  import dot_result_collect_pkg::*;
#(
  parameter int SHAPE_N       = 4,
  parameter int ELEMENT_WIDTH = 9,
  parameter int DEPTH_WARP    = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [ELEMENT_WIDTH-1:0]         result_i,
  input  logic [FFLAGS_W-1:0]              fflags_i,
  input  logic [REG_IDX_W-1:0]             ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]            ctrl_warpid_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [SHAPE_N*ELEMENT_WIDTH-1:0] data_o,
  output logic [FFLAGS_W-1:0]              fflags_o,
  output logic [REG_IDX_W-1:0]             reg_idxw_o,
  output logic [DEPTH_WARP-1:0]            warpid_o,
  output logic                             err_o
);

  localparam int DATA_W = SHAPE_N * ELEMENT_WIDTH;
  localparam int CNT_W  = $clog2(SHAPE_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHAPE_N - 1);

`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [FFLAGS_W-1:0]   fflags;
    logic [REG_IDX_W-1:0]  reg_idxw;
    logic [DEPTH_WARP-1:0] warpid;
  } pkt_t;
`else
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_IDX_W-1:0]  reg_idxw;
    logic [DEPTH_WARP-1:0] warpid;
  } pkt_t;
`endif

  fill_state_e                           state_q, state_d;
  logic [CNT_W-1:0]                      count_q;
  logic [SHAPE_N-1:0][ELEMENT_WIDTH-1:0] lanes_q, lanes_cat;
  logic [REG_IDX_W-1:0]                  tag_reg_q;
  logic [DEPTH_WARP-1:0]                 tag_warp_q;
  logic                                  err_q;
  logic                                  accept, tag_miss, is_last, restart;
  logic                                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  pkt_t                                  pkt_d, fifo_dout, hold_q, out_pkt;

`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
  logic [FFLAGS_W-1:0] flags_q;
`else
  logic unused_fflags;
  assign unused_fflags = ^fflags_i;
`endif

  assign accept   = in_valid_i & in_ready_o;
  assign tag_miss = (state_q == ST_FILL) &&
                    ((ctrl_reg_idxw_i != tag_reg_q) || (ctrl_warpid_i != tag_warp_q));
  assign is_last  = (state_q == ST_FILL) && (count_q == LAST) && !tag_miss;
  // A tag mismatch abandons the partial packet and restarts with the offending element.
  assign restart  = (state_q == ST_IDLE) || tag_miss;
  assign fifo_pop = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)           state_d = ST_FILL;
      ST_FILL: if (accept && is_last) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b1;
    if ((count_q == LAST) && fifo_full && !fifo_pop) in_ready_o = 1'b0;
    fifo_push = accept & is_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      lanes_q    <= '0;
      tag_reg_q  <= '0;
      tag_warp_q <= '0;
      err_q      <= 1'b0;
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
      flags_q    <= '0;
`endif
    end else begin
      err_q <= accept & tag_miss;
      if (accept) begin
        if (restart) begin
          lanes_q[0] <= result_i;
          tag_reg_q  <= ctrl_reg_idxw_i;
          tag_warp_q <= ctrl_warpid_i;
          count_q    <= CNT_W'(1);
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
          flags_q    <= fflags_i;
`endif
        end else begin
          lanes_q[count_q] <= result_i;
          count_q          <= is_last ? '0 : count_q + 1'b1;
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
          flags_q          <= flags_q | fflags_i;
`endif
        end
      end
    end
  end

  // The final element bypasses the lane registers straight into the FIFO.
  always_comb begin
    lanes_cat            = lanes_q;
    lanes_cat[SHAPE_N-1] = result_i;
    pkt_d                = '0;
    pkt_d.data           = lanes_cat;
    pkt_d.reg_idxw       = tag_reg_q;
    pkt_d.warpid         = tag_warp_q;
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
    pkt_d.fflags         = flags_q | fflags_i;
`endif
  end

  sync_fifo #(
    .WIDTH($bits(pkt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .din_i  (pkt_d),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Outputs keep showing the last delivered packet while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hold_q <= '0;
    else if (fifo_pop) hold_q <= fifo_dout;
  end

  assign out_valid_o = ~fifo_empty;
  assign out_pkt     = out_valid_o ? fifo_dout : hold_q;
  assign data_o      = out_pkt.data;
  assign reg_idxw_o  = out_pkt.reg_idxw;
  assign warpid_o    = out_pkt.warpid;
  assign err_o       = err_q;
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
  assign fflags_o    = out_pkt.fflags;
`else
  assign fflags_o    = '0;
`endif

endmodule

// File: tb/tb_dot_result_collect.sv
// Scoreboard bench for dot_result_collect at SHAPE_N=4, ELEMENT_WIDTH=9, FIFO_DEPTH=2.
module tb_dot_result_collect;

  localparam int SN = 4;
  localparam int EW = 9;
  localparam int WW = 4;
  localparam int DW = SN * EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] result = '0;
  logic [4:0]    fflags = '0;
  logic [7:0]    ctrl_reg = '0;
  logic [WW-1:0] ctrl_warp = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_o;
  logic [4:0]    fflags_o;
  logic [7:0]    reg_idxw_o;
  logic [WW-1:0] warpid_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    fl;
    logic [7:0]    rg;
    logic [WW-1:0] wp;
  } exp_t;

  exp_t sb[$];

  dot_result_collect #(
    .SHAPE_N(SN), .ELEMENT_WIDTH(EW), .DEPTH_WARP(WW), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result), .fflags_i(fflags),
    .ctrl_reg_idxw_i(ctrl_reg), .ctrl_warpid_i(ctrl_warp),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data_o), .fflags_o(fflags_o),
    .reg_idxw_o(reg_idxw_o), .warpid_o(warpid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_fl(input logic [4:0] f);
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
    return f;
`else
    return 5'b0 & f;
`endif
  endfunction

  // Every handshake on the output side is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet data=%h reg=%h warp=%h, no packet expected", data_o, reg_idxw_o, warpid_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({data_o, fflags_o, reg_idxw_o, warpid_o} !== {e.data, e.fl, e.rg, e.wp}) begin
          errors++;
          $display("FAIL packet got data=%h fl=%b reg=%h warp=%h, expected data=%h fl=%b reg=%h warp=%h",
                   data_o, fflags_o, reg_idxw_o, warpid_o, e.data, e.fl, e.rg, e.wp);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the element is accepted.
  task automatic send(input logic [EW-1:0] r, input logic [4:0] f, input logic [7:0] rg,
                      input logic [WW-1:0] wp, output int waited);
    in_valid = 1'b1; result = r; fflags = f; ctrl_reg = rg; ctrl_warp = wp;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b, required 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [EW-1:0] base, input logic [4:0] fl, input logic [7:0] rg,
                          input logic [WW-1:0] wp);
    exp_t e;
    e.data = '0;
    for (int k = 0; k < SN; k++) e.data[k*EW +: EW] = base + EW'(k);
    e.fl = exp_fl(fl); e.rg = rg; e.wp = wp;
    sb.push_back(e);
  endtask

  task automatic send_packet(input logic [EW-1:0] base, input logic [4:0] f0, input logic [4:0] f3,
                             input logic [7:0] rg, input logic [WW-1:0] wp);
    int w;
    push_exp(base, f0 | f3, rg, wp);
    for (int k = 0; k < SN; k++)
      send(base + EW'(k), (k == 0) ? f0 : ((k == SN-1) ? f3 : 5'b0), rg, wp, w);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #2 out_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b, required 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (data_o !== '0)      begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    checks++; if (fflags_o !== 5'b0)  begin errors++; $display("FAIL reset_fflags got %b want 0", fflags_o); end
    checks++; if (reg_idxw_o !== 8'h0) begin errors++; $display("FAIL reset_reg got %h want 0", reg_idxw_o); end
    checks++; if (warpid_o !== '0)    begin errors++; $display("FAIL reset_warp got %h want 0", warpid_o); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] want;
    want = {9'h004, 9'h003, 9'h002, 9'h001};
    set_ready(1'b1);
    send_packet(9'h001, 5'b0, 5'b0, 8'h10, 4'd3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
    checks++; if (data_o !== want)    begin errors++; $display("FAIL basic_data got %h want %h", data_o, want); end
    checks++; if (reg_idxw_o !== 8'h10) begin errors++; $display("FAIL basic_reg got %h want 10", reg_idxw_o); end
    checks++; if (warpid_o !== 4'd3)  begin errors++; $display("FAIL basic_warp got %h want 3", warpid_o); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    set_ready(1'b0);
    send_packet(9'h020, 5'b0, 5'b0, 8'h21, 4'd1);
    send_packet(9'h030, 5'b0, 5'b0, 8'h22, 4'd2);
    push_exp(9'h040, 5'b0, 8'h23, 4'd4);
    for (int k = 0; k < SN-1; k++) send(9'h040 + EW'(k), 5'b0, 8'h23, 4'd4, w);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid out_valid got %b want 1", out_valid); end
    fork
      send(9'h043, 5'b0, 8'h23, 4'd4, w);
      begin repeat (4) @(posedge clk); #2 out_ready = 1'b1; end
    join
    checks++; if (w < 3) begin errors++; $display("FAIL bp_wait waited %0d cycles, required at least 3", w); end
    wait_drain();
  endtask

  task automatic test_push_pop_full();
    int w;
    set_ready(1'b0);
    send_packet(9'h060, 5'b0, 5'b0, 8'h31, 4'd1);
    send_packet(9'h070, 5'b0, 5'b0, 8'h32, 4'd2);
    push_exp(9'h080, 5'b0, 8'h33, 4'd3);
    for (int k = 0; k < SN-1; k++) send(9'h080 + EW'(k), 5'b0, 8'h33, 4'd3, w);
    @(posedge clk); #2;
    out_ready = 1'b1; in_valid = 1'b1; result = 9'h083; fflags = 5'b0; ctrl_reg = 8'h33; ctrl_warp = 4'd3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready in_ready got %b want 1", in_ready); end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_bubble out_valid got %b want 1", out_valid); end
    push_exp(9'h090, 5'b0, 8'h34, 4'd5);
    for (int k = 0; k < SN-1; k++) send(9'h090 + EW'(k), 5'b0, 8'h34, 4'd5, w);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_occupancy in_ready got %b want 0 (FIFO full)", in_ready); end
    fork
      send(9'h093, 5'b0, 8'h34, 4'd5, w);
      begin repeat (2) @(posedge clk); #2 out_ready = 1'b1; end
    join
    wait_drain();
  endtask

  task automatic test_tag_mismatch();
    int w;
    set_ready(1'b1);
    send(9'h050, 5'b00100, 8'h30, 4'd3, w);
    send(9'h051, 5'b00000, 8'h30, 4'd3, w);
    push_exp(9'h052, 5'b01010, 8'h30, 4'd5);
    send(9'h052, 5'b00010, 8'h30, 4'd5, w);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mismatch_err got %b want 1", err_o); end
    @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mismatch_pulse err got %b want 0", err_o); end
    send(9'h053, 5'b00000, 8'h30, 4'd5, w);
    send(9'h054, 5'b00000, 8'h30, 4'd5, w);
    send(9'h055, 5'b01000, 8'h30, 4'd5, w);
    wait_drain();
  endtask

  task automatic test_fflags();
    logic [4:0] want;
`ifdef DOT_RESULT_COLLECT_FFLAGS_EN
    want = 5'b10001;
`else
    want = 5'b00000;
`endif
    send_packet(9'h0A0, 5'b00001, 5'b10000, 8'h40, 4'd7);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fflags_valid got %b want 1", out_valid); end
    checks++; if (fflags_o !== want)  begin errors++; $display("FAIL fflags_or got %b want %b", fflags_o, want); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int w;
    set_ready(1'b0);
    send_packet(9'h0B0, 5'b0, 5'b0, 8'h41, 4'd1);
    send(9'h0C0, 5'b0, 8'h42, 4'd2, w);
    send(9'h0C1, 5'b0, 8'h42, 4'd2, w);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    set_ready(1'b1);
    push_exp(9'h0D0, 5'b0, 8'h43, 4'd6);
    for (int k = 0; k < SN-1; k++) send(9'h0D0 + EW'(k), 5'b0, 8'h43, 4'd6, w);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early got out_valid %b want 0", out_valid); end
    send(9'h0D3, 5'b0, 8'h43, 4'd6, w);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_fresh got out_valid %b want 1", out_valid); end
    wait_drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_push_pop_full();
    test_tag_mismatch();
    test_fflags();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_result_collect.md
DOT_RESULT_COLLECT -- requirements
Module: dot_result_collect

Interface
REQ-001 SHALL have parameter SHAPE_N, default 4: reduction-tree results packed per output packet (power of two, ≥2).
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 9: width of one tree result.
REQ-003 SHALL have parameter DEPTH_WARP, default 4: warp-id width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: completed-packet buffer entries (≥1).
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid_i, input, 1: upstream tree result valid.
REQ-008 SHALL have port in_ready_o, output, 1: block accepts a result.
REQ-009 SHALL have port result_i, input, ELEMENT_WIDTH: tree sum.
REQ-010 SHALL have port fflags_i, input, 5: tree exception flags.
REQ-011 SHALL have port ctrl_reg_idxw_i, input, 8: destination register tag.
REQ-012 SHALL have port ctrl_warpid_i, input, DEPTH_WARP: warp tag.
REQ-013 SHALL have port out_valid_o, output, 1: packet valid.
REQ-014 SHALL have port out_ready_i, input, 1: writeback accepts packet.
REQ-015 SHALL have port data_o, output, SHAPE_N*ELEMENT_WIDTH: packed results.
REQ-016 SHALL have port fflags_o, output, 5: packet flags.
REQ-017 SHALL have port reg_idxw_o, output, 8; and warpid_o, output, DEPTH_WARP: packet tags.
REQ-018 SHALL have port err_o, output, 1: one-cycle tag-mismatch pulse.

Function
REQ-019 Transfer on in_valid_i&in_ready_o; result k of a packet (k=0..SHAPE_N-1) SHALL land in data_o[(k+1)*ELEMENT_WIDTH-1 -: ELEMENT_WIDTH], lane 0 at LSB.
REQ-020 Fill FSM SHALL have states IDLE (count=0) and FILL (count 1..SHAPE_N-1); IDLE->FILL on accept, FILL->IDLE on accepting element SHAPE_N-1, else hold.
REQ-021 Element 0 SHALL latch reg_idxw/warpid tags; final element SHALL push {data, flags, tags} into the FIFO.
REQ-022 Pushed packet SHALL appear on out_valid_o the cycle after the final element is accepted (1-cycle latency), held stable until out_valid_o&out_ready_i.
REQ-023 in_ready_o SHALL be 1 except when count=SHAPE_N-1 and FIFO full and no pop in the same cycle.
REQ-024 Simultaneous push and pop on a full FIFO SHALL both succeed; occupancy unchanged.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-026 An element with k>0 whose tags differ from latched tags SHALL pulse err_o for one cycle, discard the partial packet, and be taken as element 0 of a new packet.
REQ-027 out_valid_o=0 when FIFO empty; data_o/fflags_o/tags then don't-care but held at last value.

Reset
REQ-028 Reset SHALL force count=0 (IDLE), FIFO empty, in_ready_o=1, out_valid_o=0, err_o=0, data_o=0, fflags_o=0, reg_idxw_o=0, warpid_o=0.
REQ-029 Reset mid-packet or with full FIFO SHALL drop all partial and buffered data; no packet emitted after release until SHAPE_N new results are accepted.

Configuration
REQ-030 With DOT_RESULT_COLLECT_FFLAGS_EN defined, fflags_o SHALL be the bitwise OR of fflags_i of all SHAPE_N elements of the packet.
REQ-031 Without DOT_RESULT_COLLECT_FFLAGS_EN, fflags_o SHALL be constant 0 and no flag storage SHALL exist.

Structure
REQ-032 Shared package SHALL hold the fflags width (5), register-tag width (8) and packet struct typedef {data, fflags, reg_idxw, warpid}.
REQ-033 Packet buffer SHALL be a sub-module sync_fifo parameterised by width and FIFO_DEPTH; fill FSM and packing stay in dot_result_collect.

Verification
REQ-034 SHAPE_N=4, results 0x001,0x002,0x003,0x004, tags 0x10/3, out_ready_i=1 -> one cycle later out_valid_o=1, data_o=0x004_003_002_001 lanes (lane0 LSB), reg_idxw_o=0x10, warpid_o=3.
REQ-035 out_ready_i=0, stream 3 packets -> 2 buffered, in_ready_o=0 at 4th element of packet 3 until out_ready_i=1; all 3 packets emitted in order.
REQ-036 Full FIFO, final element and pop same cycle -> both accepted, occupancy stays 2, no bubble.
REQ-037 Element 2 with warpid 5 vs latched 3 -> err_o=1 for one cycle, next packet starts with that element; previous partial never emitted.
REQ-038 FFLAGS_EN defined, element flags 5'b00001 and 5'b10000 within a packet -> fflags_o=5'b10001; undefined -> 5'b00000.
REQ-039 rst_n low after 2 elements with 1 packet buffered -> out_valid_o=0 immediately; next packet requires 4 fresh elements.
